// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch queue: FSM state and the {instr, pc+4} queue entry.
package ifetch_pkg;

  localparam int IFQ_W = 32;

  typedef enum logic {S_IDLE, S_REQ} ifq_state_t;

  typedef struct packed {
    logic [IFQ_W-1:0] instr;
    logic [IFQ_W-1:0] pc4;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory request bus between the fetch front end (master) and the memory (slave).
interface ifetch_queue_if #(
  parameter int W = 32
);

  logic         instrreq;
  logic [W-1:0] instradr;
  logic         instrabort;
  logic [W-1:0] instrF;

  modport master (output instrreq, instradr, input instrabort, instrF);
  modport slave  (input instrreq, instradr, output instrabort, instrF);

endinterface

// File: rtl/ifq_fifo.sv
// Prefetch queue storage: circular buffer with push/pop/flush; flush has priority.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  ifq_entry_t                 wdata_i,
  output ifq_entry_t                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  ifq_entry_t      mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (do_pop) rd_d = rd_q + PW'(1);
      if (push_i && !do_pop)      count_d = count_q + CW'(1);
      else if (!push_i && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: memory req/abort handshake feeding a prefetch queue, with redirect flush.
// Define IFQ_STATS_EN to add the stat_fetch/stat_drop transfer counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int           W        = 32,
  parameter int           DEPTH    = 4,
  parameter int           MIN_WAIT = 5,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master imem,
  input  logic           stallD,
  input  logic           redirect,
  input  logic [W-1:0]   redirect_pc,
  output logic           instr_valid,
  output logic [W-1:0]   instrD,
  output logic [W-1:0]   pc4D
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]    stat_fetch,
  output logic [31:0]    stat_drop
`endif
);

  localparam int             CW         = $clog2(DEPTH + 1);
  localparam int             WCW        = (MIN_WAIT > 0) ? $clog2(MIN_WAIT + 1) : 1;
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [WCW-1:0] MIN_WAIT_C = WCW'(MIN_WAIT);
  localparam logic [W-1:0]   PC_STEP    = W'(4);

  ifq_state_t     state_q, state_d;
  logic [W-1:0]   req_pc_q, req_pc_d;
  logic [W-1:0]   fetch_pc_q, fetch_pc_d;
  logic           drop_q, drop_d;
  logic [WCW-1:0] waitcnt_q, waitcnt_d;

  logic           complete, keep;
  logic [CW-1:0]  count;
  ifq_entry_t     head, wentry;

  assign complete = (state_q == S_REQ) && (waitcnt_q == MIN_WAIT_C) && !imem.instrabort;
  assign keep     = complete && !drop_q && !redirect;

  // A redirect while a transfer is outstanding cannot cancel it on the bus; drop_q marks its data as stale.
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    waitcnt_d  = waitcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect && (count < DEPTH_C)) begin
          state_d   = S_REQ;
          req_pc_d  = fetch_pc_q;
          waitcnt_d = '0;
        end
      end
      S_REQ: begin
        if (complete) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (keep) fetch_pc_d = req_pc_q + PC_STEP;
        end else begin
          if (waitcnt_q != MIN_WAIT_C) waitcnt_d = waitcnt_q + WCW'(1);
          if (redirect) drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_pc_q   <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      waitcnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      waitcnt_q  <= waitcnt_d;
    end
  end

  assign imem.instrreq = (state_q == S_REQ);
  assign imem.instradr = req_pc_q;

  assign wentry = '{instr: imem.instrF, pc4: req_pc_q + PC_STEP};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (keep),
    .pop_i   (instr_valid && !stallD && !redirect),
    .flush_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign instrD      = head.instr;
  assign pc4D        = head.pc4;

`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetch_q, stat_drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetch_q <= '0;
      stat_drop_q  <= '0;
    end else if (complete) begin
      if (keep) stat_fetch_q <= stat_fetch_q + 32'd1;
      else      stat_drop_q  <= stat_drop_q + 32'd1;
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_drop  = stat_drop_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a transaction-level queue model.
module tb_ifetch_queue;

  localparam int          W        = 32;
  localparam int          DEPTH    = 4;
  localparam int          MIN_WAIT = 5;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallD, redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instrD, pc4D;
`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetch, stat_drop;
`endif

  ifetch_queue_if #(.W(W)) imem ();

  ifetch_queue #(
    .W        (W),
    .DEPTH    (DEPTH),
    .MIN_WAIT (MIN_WAIT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .stallD      (stallD),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instrD      (instrD),
    .pc4D        (pc4D)
`ifdef IFQ_STATS_EN
    ,
    .stat_fetch  (stat_fetch),
    .stat_drop   (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  // Reference: an outstanding fetch is {busy, address, cycles held, stale?}; the queue is a plain SV queue.
  ent_t        mq[$];
  bit          m_busy, m_discard;
  int unsigned m_held;
  logic [31:0] m_addr, m_next;
  int unsigned m_fetch, m_drop;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_held    = 0;
    m_addr    = RESET_PC;
    m_next    = RESET_PC;
    m_fetch   = 0;
    m_drop    = 0;
  endfunction

  function automatic void model_step(input bit ab, input bit st, input bit rd,
                                     input logic [31:0] rpc, input logic [31:0] data);
    int unsigned sz0  = mq.size();
    bit          done = m_busy && (m_held >= MIN_WAIT) && !ab;
    bit          kept = done && !m_discard && !rd;
    if (done) begin
      if (kept) m_fetch++;
      else      m_drop++;
    end
    if (rd) mq.delete();
    else begin
      if (sz0 != 0 && !st) void'(mq.pop_front());
      if (kept) mq.push_back('{instr: data, pc4: m_addr + 32'd4});
    end
    if (m_busy) begin
      if (done) begin
        m_busy = 1'b0;
        if (kept) m_next = m_addr + 32'd4;
        m_discard = 1'b0;
      end else begin
        m_held++;
        if (rd) m_discard = 1'b1;
      end
    end else if (!rd && sz0 < DEPTH) begin
      m_busy = 1'b1;
      m_addr = m_next;
      m_held = 0;
    end
    if (rd) m_next = rpc;
  endfunction

  task automatic compare_outputs();
    logic [31:0] ei, ep;
    ei = (mq.size() != 0) ? mq[0].instr : 32'h0;
    ep = (mq.size() != 0) ? mq[0].pc4   : 32'h0;
    check_eq("instrreq", 32'(imem.instrreq), 32'(m_busy));
    check_eq("instradr", imem.instradr, m_addr);
    check_eq("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    check_eq("instrD", instrD, ei);
    check_eq("pc4D", pc4D, ep);
`ifdef IFQ_STATS_EN
    check_eq("stat_fetch", stat_fetch, m_fetch);
    check_eq("stat_drop", stat_drop, m_drop);
`endif
  endtask

  // Called at a negedge: apply inputs, advance the model, then check after the next rising edge.
  task automatic drive(input bit ab, input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] d;
    d               = $urandom;
    imem.instrabort = ab;
    imem.instrF     = d;
    stallD          = st;
    redirect        = rd;
    redirect_pc     = rpc;
    model_step(ab, st, rd, rpc, d);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    imem.instrabort = 1'b0;
    imem.instrF     = '0;
    stallD          = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    #1;
    check_eq("rst_instrreq", 32'(imem.instrreq), 32'h0);
    check_eq("rst_instradr", imem.instradr, RESET_PC);
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_instrD", instrD, 32'h0);
    check_eq("rst_pc4D", pc4D, 32'h0);
`ifdef IFQ_STATS_EN
    check_eq("rst_stat_drop", stat_drop, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    compare_outputs();
  endtask

  task automatic rand_phase(input int n, input int p_ab, input int p_st, input int p_rd);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 99) < p_ab, $urandom_range(0, 99) < p_st,
            $urandom_range(0, 99) < p_rd, {22'h0, 8'($urandom_range(0, 255)), 2'b00});
    end
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    imem.instrabort = 1'b0;
    imem.instrF     = '0;
    stallD          = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    @(negedge clk);
    do_reset();

    // First fetch at RESET_PC, entry {instrF, 4} one cycle after the completion cycle.
    drive(0, 0, 0, 0);
    check_eq("s1_req", 32'(imem.instrreq), 32'h1);
    check_eq("s1_adr", imem.instradr, 32'h0);
    repeat (MIN_WAIT + 1) drive(0, 1, 0, 0);
    check_eq("s1_push_valid", 32'(instr_valid), 32'h1);
    check_eq("s1_push_pc4", pc4D, 32'h4);

    // Held stall fills the queue, then fetching stops.
    repeat (40) drive(0, 1, 0, 0);
    check_eq("s2_full_req", 32'(imem.instrreq), 32'h0);
    check_eq("s2_full_head", pc4D, 32'h4);
    repeat (12) drive(0, 0, 0, 0);

    // Redirect while the fetch at 0x8 is outstanding.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (m_busy && m_addr == 32'h8 && m_held == 2) break;
      drive(0, 0, 0, 0);
    end
    check_eq("s4_at8", imem.instradr, 32'h8);
    drive(0, 0, 1, 32'h100);
    check_eq("s4_empty", 32'(instr_valid), 32'h0);
    check_eq("s4_still_req", 32'(imem.instrreq), 32'h1);
    for (int i = 0; i < 30; i++) begin
      if (m_busy && m_addr == 32'h100) break;
      drive(0, 0, 0, 0);
    end
    check_eq("s4_adr", imem.instradr, 32'h100);
`ifdef IFQ_STATS_EN
    check_eq("s4_stat_drop", stat_drop, 32'h1);
`endif

    // Redirect in the completion cycle with a non-empty queue and a pop requested.
    for (int i = 0; i < 40; i++) begin
      if (m_busy && m_held >= MIN_WAIT && mq.size() != 0) break;
      drive(0, 1, 0, 0);
    end
    drive(0, 0, 1, 32'h200);
    check_eq("s5_empty", 32'(instr_valid), 32'h0);
    check_eq("s5_idle", 32'(imem.instrreq), 32'h0);
    drive(0, 0, 0, 0);
    check_eq("s5_adr", imem.instradr, 32'h200);

    // Abort held well past MIN_WAIT; the push lands when abort falls.
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_held >= MIN_WAIT) break;
      drive(0, 0, 0, 0);
    end
    a = imem.instradr;
    repeat (10) drive(1, 0, 0, 0);
    check_eq("s3_hold_adr", imem.instradr, a);
    check_eq("s3_no_push", 32'(instr_valid), 32'h0);
    drive(0, 0, 0, 0);
    check_eq("s3_push", 32'(instr_valid), 32'h1);
    check_eq("s3_pc4", pc4D, a + 32'd4);

    rand_phase(600, 20, 30, 3);
    rand_phase(600, 60, 70, 1);
    rand_phase(600, 5, 10, 15);

    // Asynchronous reset in the middle of a request.
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_held > 0) break;
      drive(0, 0, 0, 0);
    end
    #2;
    do_reset();
    drive(0, 0, 0, 0);
    check_eq("s6_req", 32'(imem.instrreq), 32'h1);
    check_eq("s6_adr", imem.instradr, RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
